// File: rtl/sobel_pkg.sv
// Shared state encoding and window geometry for the Sobel window scheduler.
package sobel_pkg;

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      PRIME   = 5'b00010,
      SHIFT   = 5'b00100,
      PRESENT = 5'b01000,
      DONE    = 5'b10000
   } state_t;

   localparam int WIN_PIXELS = 9;

endpackage

// File: rtl/sobel_window_regs.sv
// 3x3 pixel window: single-pixel load at a row-major index, or a left shift of all three
// rows (col0<=col1, col1<=col2) ahead of reloading col2. Updates one cycle after the request.
module sobel_window_regs
   import sobel_pkg::*;
#(
   parameter int width = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_en,
   input  logic [3:0]                  load_idx,
   input  logic                        shift_en,
   input  logic [width-1:0]            din,
   output logic [WIN_PIXELS*width-1:0] win_data
);

   logic [width-1:0] px [WIN_PIXELS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIN_PIXELS; i++) px[i] <= '0;
      end else if (shift_en) begin
         for (int r = 0; r < 3; r++) begin
            px[3*r]   <= px[3*r+1];
            px[3*r+1] <= px[3*r+2];
         end
      end else if (load_en) begin
         px[load_idx] <= din;
      end
   end

   always_comb begin
      win_data = '0;
      for (int k = 0; k < WIN_PIXELS; k++) win_data[width*k +: width] = px[k];
   end

endmodule

// File: rtl/sobel_window_scheduler.sv
// Walks a 3x3 window over the image: 9 reads to prime a row, 3 per column step; window held until win_ready.
// First window 11 cycles after Start, 5 after a column step. SOBEL_SCHED_PERF_EN adds perf counters.
module sobel_window_scheduler
   import sobel_pkg::*;
#(
   parameter int width          = 8,
   parameter int IMG_W          = 128,
   parameter int IMG_H          = 128,
   parameter int A_depth_bits   = 14,
   parameter int OUT_depth_bits = 14
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        Start,
   output logic                        Done,
   output logic                        A_read_en,
   output logic [A_depth_bits-1:0]     A_read_address,
   input  logic [width-1:0]            A_read_data_out,
   output logic                        win_valid,
   input  logic                        win_ready,
   output logic [WIN_PIXELS*width-1:0] win_data,
   output logic [OUT_depth_bits-1:0]   out_address
`ifdef SOBEL_SCHED_PERF_EN
   ,
   output logic [31:0]                 perf_cycles,
   output logic [31:0]                 perf_stalls
`endif
);

   localparam int WR_W = $clog2(IMG_H);
   localparam int WC_W = $clog2(IMG_W);
   localparam logic [WR_W-1:0] WR_LAST = WR_W'(IMG_H - 3);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(IMG_W - 3);
   localparam logic [A_depth_bits-1:0] STEP_COL  = A_depth_bits'(1);
   localparam logic [A_depth_bits-1:0] STEP_WRAP = A_depth_bits'(IMG_W - 2);
   localparam logic [A_depth_bits-1:0] STEP_DOWN = A_depth_bits'(IMG_W);
   localparam logic [A_depth_bits-1:0] STEP_NEW  = A_depth_bits'(3);

   state_t                  state;
   logic [WR_W-1:0]         wr;
   logic [WC_W-1:0]         wc;
   logic [A_depth_bits-1:0] base_addr;
   logic [3:0]              rd_cnt;
   logic [3:0]              cap_cnt;
   logic [1:0]              rd_col;
   logic                    cap_vld;
   logic                    load_en;
   logic                    shift_en;
   logic [3:0]              load_idx;
   logic                    accept;

   assign accept = win_valid && win_ready;

   // PRIME fills the window row-major; SHIFT refills only column 2 of each row.
   always_comb begin
      load_en  = cap_vld && (state == PRIME || state == SHIFT);
      load_idx = (state == PRIME) ? cap_cnt : 4'(cap_cnt * 4'd3 + 4'd2);
      shift_en = accept && (wc != WC_LAST);
   end

   sobel_window_regs #(.width(width)) u_regs (
      .clk      (clk),
      .rst      (rst),
      .load_en  (load_en),
      .load_idx (load_idx),
      .shift_en (shift_en),
      .din      (A_read_data_out),
      .win_data (win_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         Done           <= 1'b0;
         A_read_en      <= 1'b0;
         A_read_address <= '0;
         win_valid      <= 1'b0;
         out_address    <= '0;
         wr             <= '0;
         wc             <= '0;
         base_addr      <= '0;
         rd_cnt         <= '0;
         cap_cnt        <= '0;
         rd_col         <= '0;
         cap_vld        <= 1'b0;
      end else begin
         cap_vld <= A_read_en;
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state          <= PRIME;
                  Done           <= 1'b0;
                  wr             <= '0;
                  wc             <= '0;
                  base_addr      <= '0;
                  out_address    <= '0;
                  A_read_en      <= 1'b1;
                  A_read_address <= '0;
                  rd_cnt         <= 4'd1;
                  rd_col         <= '0;
                  cap_cnt        <= '0;
               end
            end
            PRIME: begin
               if (rd_cnt < 4'(WIN_PIXELS)) begin
                  A_read_en      <= 1'b1;
                  A_read_address <= A_read_address + ((rd_col == 2'd2) ? STEP_WRAP : STEP_COL);
                  rd_col         <= (rd_col == 2'd2) ? 2'd0 : rd_col + 2'd1;
                  rd_cnt         <= rd_cnt + 4'd1;
               end else begin
                  A_read_en <= 1'b0;
               end
               if (cap_vld) begin
                  cap_cnt <= cap_cnt + 4'd1;
                  if (cap_cnt == 4'(WIN_PIXELS - 1)) begin
                     state     <= PRESENT;
                     win_valid <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (rd_cnt < 4'd3) begin
                  A_read_en      <= 1'b1;
                  A_read_address <= A_read_address + STEP_DOWN;
                  rd_cnt         <= rd_cnt + 4'd1;
               end else begin
                  A_read_en <= 1'b0;
               end
               if (cap_vld) begin
                  cap_cnt <= cap_cnt + 4'd1;
                  if (cap_cnt == 4'd2) begin
                     state     <= PRESENT;
                     win_valid <= 1'b1;
                  end
               end
            end
            PRESENT: begin
               if (win_ready) begin
                  win_valid <= 1'b0;
                  cap_cnt   <= '0;
                  rd_cnt    <= 4'd1;
                  rd_col    <= '0;
                  if (wc != WC_LAST) begin
                     // New column wc+1 needs pixels at column (wc+1)+2 = base+3.
                     state          <= SHIFT;
                     wc             <= wc + WC_W'(1);
                     base_addr      <= base_addr + STEP_COL;
                     A_read_en      <= 1'b1;
                     A_read_address <= base_addr + STEP_NEW;
                     out_address    <= out_address + OUT_depth_bits'(1);
                  end else if (wr != WR_LAST) begin
                     // wc is IMG_W-3 here, so base+3 is the start of the next row.
                     state          <= PRIME;
                     wr             <= wr + WR_W'(1);
                     wc             <= '0;
                     base_addr      <= base_addr + STEP_NEW;
                     A_read_en      <= 1'b1;
                     A_read_address <= base_addr + STEP_NEW;
                     out_address    <= out_address + OUT_depth_bits'(1);
                  end else begin
                     state <= DONE;
                     Done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOBEL_SCHED_PERF_EN
   // The Start cycle counts as the first busy cycle of the frame, hence the load of 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else if ((state == IDLE || state == DONE) && Start) begin
         perf_cycles <= 32'd1;
         perf_stalls <= '0;
      end else begin
         if (state != IDLE && state != DONE && perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
         if (win_valid && !win_ready && perf_stalls != '1)
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Scheduler bench on a 5x4 image with A[i]=i: expected windows and read addresses are queued at Start
// and checked by a negedge monitor.
module tb_sobel_window_scheduler;

   logic        clk;
   logic        rst;
   logic        Start;
   logic        Done;
   logic        A_read_en;
   logic [13:0] A_read_address;
   logic [7:0]  A_read_data_out;
   logic        win_valid;
   logic        win_ready;
   logic [71:0] win_data;
   logic [13:0] out_address;
`ifdef SOBEL_SCHED_PERF_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_stalls;
`endif

   sobel_window_scheduler #(
      .width(8), .IMG_W(5), .IMG_H(4), .A_depth_bits(14), .OUT_depth_bits(14)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .Start           (Start),
      .Done            (Done),
      .A_read_en       (A_read_en),
      .A_read_address  (A_read_address),
      .A_read_data_out (A_read_data_out),
      .win_valid       (win_valid),
      .win_ready       (win_ready),
      .win_data        (win_data),
      .out_address     (out_address)
`ifdef SOBEL_SCHED_PERF_EN
      ,
      .perf_cycles     (perf_cycles),
      .perf_stalls     (perf_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A_RAM model: A[i] = i, one-cycle read latency.
   always @(posedge clk) if (A_read_en) A_read_data_out <= A_read_address[7:0];

   typedef struct packed {
      logic [71:0] d;
      logic [13:0] a;
   } win_t;

   win_t exp_q[$];
   int   rd_q[$];
   int   checks = 0;
   int   errors = 0;

   // Hand-computed for the 5x4 image: window base address per origin, pixel offsets within a window,
   // and the full read sequence of one frame (primes on rows 0/1, single columns otherwise).
   int base_tab [6]  = '{0, 1, 2, 5, 6, 7};
   int off_tab  [9]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
   int rd_tab   [30] = '{0, 1, 2, 5, 6, 7, 10, 11, 12,  3, 8, 13,  4, 9, 14,
                         5, 6, 7, 10, 11, 12, 15, 16, 17,  8, 13, 18,  9, 14, 19};

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic push_frame();
      logic [71:0] d;
      for (int w = 0; w < 6; w++) begin
         d = '0;
         for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'(base_tab[w] + off_tab[k]);
         exp_q.push_back('{d: d, a: 14'(w)});
      end
      for (int i = 0; i < 30; i++) rd_q.push_back(rd_tab[i]);
   endtask

   // Monitor: every read and every accepted window is popped from the scoreboard.
   int   mon_e;
   win_t mon_w;
   always @(negedge clk) begin
      if (!rst) begin
         if (A_read_en) begin
            if (rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL read_unexpected: got address %0d expected no read", A_read_address);
            end else begin
               mon_e = rd_q.pop_front();
               chk("read_addr", 72'(A_read_address), 72'(mon_e));
            end
         end
         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL win_unexpected: got out_address %0d expected no window", out_address);
            end else begin
               mon_w = exp_q.pop_front();
               chk("win_data", win_data, mon_w.d);
               chk("out_address", 72'(out_address), 72'(mon_w.a));
            end
         end
      end
   end

   task automatic wait_valid(output int n);
      n = 1;
      while (!win_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_frame(input bit stall, input bit from_done);
      int          n;
      logic [71:0] snap_d;
      logic [13:0] snap_a;
      push_frame();
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      if (from_done) chk("done_falls", 72'(Done), 72'd0);
      for (int w = 0; w < 6; w++) begin
         wait_valid(n);
         if (!win_valid) begin
            checks++; errors++;
            $display("FAIL win_valid_timeout: window %0d never valid, expected valid", w);
            return;
         end
         chk("valid_latency", 72'(n), (w % 3 == 0) ? 72'd11 : 72'd5);
         if (stall && w == 1) begin
            snap_d = win_data;
            snap_a = out_address;
            for (int c = 0; c < 7; c++) begin
               Start = (c == 2);
               @(posedge clk); #1;
               chk("stall_data", win_data, snap_d);
               chk("stall_addr", 72'(out_address), 72'(snap_a));
               chk("stall_no_read", 72'(A_read_en), 72'd0);
               chk("stall_valid", 72'(win_valid), 72'd1);
            end
            Start = 1'b0;
         end
         if (stall) win_ready = 1'b1;
         @(posedge clk); #1;
         if (stall) win_ready = 1'b0;
      end
      chk("done_set", 72'(Done), 72'd1);
      chk("valid_after_done", 72'(win_valid), 72'd0);
      chk("win_queue_empty", 72'(exp_q.size()), 72'd0);
      chk("read_queue_empty", 72'(rd_q.size()), 72'd0);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      Start     = 1'b0;
      win_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", 72'(Done), 72'd0);
      chk("rst_read_en", 72'(A_read_en), 72'd0);
      chk("rst_read_addr", 72'(A_read_address), 72'd0);
      chk("rst_win_valid", 72'(win_valid), 72'd0);
      chk("rst_win_data", win_data, 72'd0);
      chk("rst_out_address", 72'(out_address), 72'd0);
      rst       = 1'b0;
      win_ready = 1'b1;
      @(posedge clk); #1;

      // Frame 1: win_ready held high throughout.
      run_frame(1'b0, 1'b0);
`ifdef SOBEL_SCHED_PERF_EN
      chk("perf_cycles", 72'(perf_cycles), 72'd43);
      chk("perf_stalls", 72'(perf_stalls), 72'd0);
`endif

      // Frame 2: restart from DONE, stall window 2 for 7 cycles with a Start pulse inside the stall.
      win_ready = 1'b0;
      run_frame(1'b1, 1'b1);

      // Frame 3: abort with rst while the first SHIFT is reading.
      win_ready = 1'b1;
      push_frame();
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      wait_valid(n);
      @(posedge clk); #1;
      chk("shift_reading", 72'(A_read_en), 72'd1);
      #2;
      rst = 1'b1;
      exp_q.delete();
      rd_q.delete();
      #1;
      chk("abort_done", 72'(Done), 72'd0);
      chk("abort_read_en", 72'(A_read_en), 72'd0);
      chk("abort_read_addr", 72'(A_read_address), 72'd0);
      chk("abort_win_valid", 72'(win_valid), 72'd0);
      chk("abort_win_data", win_data, 72'd0);
      chk("abort_out_address", 72'(out_address), 72'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Frame 4: clean restart from IDLE after the abort.
      run_frame(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
